// File: rtl/sha256_nonce_scheduler.sv
// Nonce search scheduler: hands nonces to a pool of single-nonce SHA-256 cores and
// funnels their H0 results onto one shared memory write port with round-robin arbitration.
module sha256_nonce_scheduler #(
   parameter int NUM_CORES  = 4,
   parameter int NUM_NONCES = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [15:0]             output_addr,
   output logic                    done,
   output logic [NUM_CORES-1:0]    core_start,
   output logic [31:0]             core_nonce,
   input  logic [NUM_CORES-1:0]    core_valid,
   input  logic [32*NUM_CORES-1:0] core_h0,
   output logic [NUM_CORES-1:0]    core_ack,
   output logic                    mem_we,
   output logic [15:0]             mem_addr,
   output logic [31:0]             mem_write_data
);

   localparam int               PTR_W       = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [15:0]      NONCE_LIMIT = 16'(NUM_NONCES);
   localparam logic [PTR_W-1:0] LAST_CORE   = PTR_W'(NUM_CORES - 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_e;

   state_e                         state_q, state_d;
   logic [15:0]                    outAddr_q, outAddr_d;
   logic [15:0]                    nextNonce_q, nextNonce_d;
   logic [15:0]                    wrCount_q, wrCount_d;
   logic [PTR_W-1:0]               rrPtr_q, rrPtr_d;
   logic [NUM_CORES-1:0]           busy_q, busy_d;
   logic [15:0]                    tag_q [NUM_CORES];
   logic [15:0]                    tag_d [NUM_CORES];

   logic                           done_q, done_d;
   logic [NUM_CORES-1:0]           coreStart_q, coreStart_d;
   logic [31:0]                    coreNonce_q, coreNonce_d;
   logic [NUM_CORES-1:0]           coreAck_q, coreAck_d;
   logic                           memWe_q, memWe_d;
   logic [15:0]                    memAddr_q, memAddr_d;
   logic [31:0]                    memData_q, memData_d;

   logic [NUM_CORES-1:0][31:0]     h0Vec;
   logic [NUM_CORES-1:0]           eligible;
   logic                           dispFound, grantFound;
   logic [PTR_W-1:0]               dispIdx, grantIdx;
   int                             cand;

   assign h0Vec = core_h0;

   always_comb begin
      dispFound = 1'b0;
      dispIdx   = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (!busy_q[i]) begin
            dispFound = 1'b1;
            dispIdx   = PTR_W'(i);
         end
      end
   end

   // Scanning backwards from the pointer leaves the nearest eligible core as the winner.
   always_comb begin
      eligible   = core_valid & busy_q;
      grantFound = 1'b0;
      grantIdx   = '0;
      cand       = 0;
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
         cand = int'(rrPtr_q) + k;
         if (cand >= NUM_CORES) begin
            cand = cand - NUM_CORES;
         end
         if (eligible[cand]) begin
            grantFound = 1'b1;
            grantIdx   = PTR_W'(cand);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      outAddr_d   = outAddr_q;
      nextNonce_d = nextNonce_q;
      wrCount_d   = wrCount_q;
      rrPtr_d     = rrPtr_q;
      busy_d      = busy_q;
      tag_d       = tag_q;
      done_d      = done_q;
      coreStart_d = '0;
      coreNonce_d = coreNonce_q;
      coreAck_d   = '0;
      memWe_d     = 1'b0;
      memAddr_d   = memAddr_q;
      memData_d   = memData_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d     = RUN;
               outAddr_d   = output_addr;
               done_d      = 1'b0;
               nextNonce_d = '0;
               wrCount_d   = '0;
               rrPtr_d     = '0;
               busy_d      = '0;
            end
         end

         RUN: begin
            // Dispatch only sees free cores from before this edge, so a core acked now waits a cycle.
            if (dispFound && (nextNonce_q < NONCE_LIMIT)) begin
               coreStart_d[dispIdx] = 1'b1;
               coreNonce_d          = {16'h0000, nextNonce_q};
               tag_d[dispIdx]       = nextNonce_q;
               busy_d[dispIdx]      = 1'b1;
               nextNonce_d          = nextNonce_q + 16'd1;
            end
            if (grantFound) begin
               memWe_d             = 1'b1;
               memAddr_d           = outAddr_q + tag_q[grantIdx];
               memData_d           = h0Vec[grantIdx];
               coreAck_d[grantIdx] = 1'b1;
               busy_d[grantIdx]    = 1'b0;
               wrCount_d           = wrCount_q + 16'd1;
               rrPtr_d             = (grantIdx == LAST_CORE) ? '0 : grantIdx + 1'b1;
               if ((wrCount_q + 16'd1) == NONCE_LIMIT) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         outAddr_q   <= '0;
         nextNonce_q <= '0;
         wrCount_q   <= '0;
         rrPtr_q     <= '0;
         busy_q      <= '0;
         tag_q       <= '{default: '0};
         done_q      <= 1'b0;
         coreStart_q <= '0;
         coreNonce_q <= '0;
         coreAck_q   <= '0;
         memWe_q     <= 1'b0;
         memAddr_q   <= '0;
         memData_q   <= '0;
      end else begin
         state_q     <= state_d;
         outAddr_q   <= outAddr_d;
         nextNonce_q <= nextNonce_d;
         wrCount_q   <= wrCount_d;
         rrPtr_q     <= rrPtr_d;
         busy_q      <= busy_d;
         tag_q       <= tag_d;
         done_q      <= done_d;
         coreStart_q <= coreStart_d;
         coreNonce_q <= coreNonce_d;
         coreAck_q   <= coreAck_d;
         memWe_q     <= memWe_d;
         memAddr_q   <= memAddr_d;
         memData_q   <= memData_d;
      end
   end

   assign done           = done_q;
   assign core_start     = coreStart_q;
   assign core_nonce     = coreNonce_q;
   assign core_ack       = coreAck_q;
   assign mem_we         = memWe_q;
   assign mem_addr       = memAddr_q;
   assign mem_write_data = memData_q;

endmodule

// File: tb/tb_sha256_nonce_scheduler.sv
// Randomized bench: behavioural hash cores feed the scheduler, and a monitor checks every
// dispatch and write against a nonce-level model with an order-tolerant write scoreboard.
module tb_sha256_nonce_scheduler;

   localparam int NUM_CORES  = 4;
   localparam int NUM_NONCES = 16;

   logic                    clk = 1'b0;
   logic                    reset_n;
   logic                    start;
   logic [15:0]             output_addr;
   logic                    done;
   logic [NUM_CORES-1:0]    core_start;
   logic [31:0]             core_nonce;
   logic [NUM_CORES-1:0]    core_valid;
   logic [32*NUM_CORES-1:0] core_h0;
   logic [NUM_CORES-1:0]    core_ack;
   logic                    mem_we;
   logic [15:0]             mem_addr;
   logic [31:0]             mem_write_data;

   always #5 clk = ~clk;

   sha256_nonce_scheduler #(
      .NUM_CORES (NUM_CORES),
      .NUM_NONCES(NUM_NONCES)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .start         (start),
      .output_addr   (output_addr),
      .done          (done),
      .core_start    (core_start),
      .core_nonce    (core_nonce),
      .core_valid    (core_valid),
      .core_h0       (core_h0),
      .core_ack      (core_ack),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_write_data(mem_write_data)
   );

   typedef struct {
      logic [15:0] addr;
      logic [31:0] data;
   } expWrite_t;

   int          compared   = 0;
   int          mismatched = 0;

   expWrite_t   expQ[$];
   bit          mRunning = 1'b0;
   bit          mDone    = 1'b0;
   logic [15:0] mBase    = '0;
   int          mNext    = 0;
   int          mWrites  = 0;
   int          mPtr     = 0;
   int          mWeCount = 0;
   bit          mBusy [NUM_CORES];
   int          mTag  [NUM_CORES];

   bit          cActive [NUM_CORES];
   bit          cReady  [NUM_CORES];
   bit          cStale  [NUM_CORES];
   int          cCount  [NUM_CORES];
   logic [15:0] cNonce  [NUM_CORES];
   int          latMode = 0;
   bit          staleEn = 1'b0;
   bit          gate    = 1'b1;
   logic [7:0]  salt    = '0;

   function automatic logic [31:0] h0Of(input logic [15:0] n, input logic [7:0] s);
      return 32'hA500_0000 + {8'h00, s, 16'h0000} + {16'h0000, n};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Behavioural cores: finish after a random latency, hold valid until acked,
   // and sometimes leave valid high one cycle past the ack.
   always @(negedge clk) begin : coreModel
      if (!reset_n) begin
         core_valid = '0;
         core_h0    = '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            cActive[i] = 1'b0;
            cReady[i]  = 1'b0;
            cStale[i]  = 1'b0;
         end
      end else begin
         for (int i = 0; i < NUM_CORES; i++) begin
            if (core_ack[i]) begin
               cActive[i] = 1'b0;
               cReady[i]  = 1'b0;
               if (staleEn && ($urandom_range(0, 1) == 1)) cStale[i] = 1'b1;
               else core_valid[i] = 1'b0;
            end else if (cStale[i]) begin
               cStale[i]     = 1'b0;
               core_valid[i] = 1'b0;
            end
            if (core_start[i]) begin
               cActive[i]    = 1'b1;
               cReady[i]     = 1'b0;
               cStale[i]     = 1'b0;
               core_valid[i] = 1'b0;
               cNonce[i]     = core_nonce[15:0];
               cCount[i]     = int'($urandom_range(0, latMode));
            end else if (cActive[i] && !cReady[i]) begin
               if (cCount[i] == 0) cReady[i] = 1'b1;
               else cCount[i]--;
            end
            if (cActive[i] && cReady[i] && !core_valid[i] && gate) begin
               core_valid[i]        = 1'b1;
               core_h0[32*i +: 32] = h0Of(cNonce[i], salt);
            end
         end
      end
   end

   // Monitor: derives the expected dispatch, grant and done from the model state as it
   // stood before this edge, then compares with the registered DUT outputs.
   always @(posedge clk) begin : monitor
      logic [NUM_CORES-1:0] elig;
      logic [NUM_CORES-1:0] expStart;
      logic [NUM_CORES-1:0] expAck;
      logic [15:0]          expAddr;
      expWrite_t            w;
      bit                   wasRunning;
      int                   g;
      int                   d;
      int                   hit;
      #1;
      if (reset_n) begin
         wasRunning = mRunning;
         expStart   = '0;
         expAck     = '0;
         for (int i = 0; i < NUM_CORES; i++) elig[i] = core_valid[i] & mBusy[i];
         d = -1;
         if (wasRunning && (mNext < NUM_NONCES)) begin
            for (int i = NUM_CORES - 1; i >= 0; i--) if (!mBusy[i]) d = i;
         end
         g = -1;
         if (wasRunning) begin
            for (int k = NUM_CORES - 1; k >= 0; k--) begin
               if (elig[(mPtr + k) % NUM_CORES]) g = (mPtr + k) % NUM_CORES;
            end
         end

         if (mem_we) mWeCount++;
         if (g >= 0) begin
            expAck[g] = 1'b1;
            expAddr   = mBase + 16'(mTag[g]);
            checkOutput("memWe", {31'b0, mem_we}, 32'd1);
            checkOutput("memAddr", {16'b0, mem_addr}, {16'b0, expAddr});
            hit = -1;
            foreach (expQ[j]) if ((hit < 0) && (expQ[j].addr == mem_addr)) hit = j;
            if (hit < 0) begin
               compared++;
               mismatched++;
               $display("[TB] FAIL unexpectedWrite: got addr 0x%0h, expected one of %0d pending", mem_addr, expQ.size());
            end else begin
               checkOutput("memData", mem_write_data, expQ[hit].data);
               expQ.delete(hit);
            end
            mBusy[g] = 1'b0;
            mPtr     = (g + 1) % NUM_CORES;
            mWrites++;
            if (mWrites == NUM_NONCES) begin
               mRunning = 1'b0;
               mDone    = 1'b1;
            end
         end else begin
            checkOutput("memWeIdle", {31'b0, mem_we}, 32'd0);
         end
         checkOutput("coreAck", {28'b0, core_ack}, {28'b0, expAck});

         if (d >= 0) begin
            expStart[d] = 1'b1;
            checkOutput("coreNonce", core_nonce, 32'(mNext));
            mBusy[d] = 1'b1;
            mTag[d]  = mNext;
            w.addr   = mBase + 16'(mNext);
            w.data   = h0Of(16'(mNext), salt);
            expQ.push_back(w);
            mNext++;
         end
         checkOutput("coreStart", {28'b0, core_start}, {28'b0, expStart});

         if (!wasRunning && start) begin
            mRunning = 1'b1;
            mDone    = 1'b0;
            mBase    = output_addr;
            mNext    = 0;
            mWrites  = 0;
            mPtr     = 0;
            mWeCount = 0;
            for (int i = 0; i < NUM_CORES; i++) mBusy[i] = 1'b0;
            expQ.delete();
         end
         checkOutput("done", {31'b0, done}, {31'b0, mDone});
      end
   end

   task automatic checkResetOutputs();
      checkOutput("rstDone", {31'b0, done}, 32'd0);
      checkOutput("rstCoreStart", {28'b0, core_start}, 32'd0);
      checkOutput("rstCoreNonce", core_nonce, 32'd0);
      checkOutput("rstCoreAck", {28'b0, core_ack}, 32'd0);
      checkOutput("rstMemWe", {31'b0, mem_we}, 32'd0);
      checkOutput("rstMemAddr", {16'b0, mem_addr}, 32'd0);
      checkOutput("rstMemData", mem_write_data, 32'd0);
   endtask

   // One run: pulse start, then let the cores and monitor work until the model sees the
   // final write; optionally spam start, gate completions into ties, or abort with reset.
   task automatic applyStimulus(input logic [15:0] base, input logic [7:0] s, input int lat,
                                input bit stale, input bit contend, input bit spam, input int abortAfter);
      int cycles;
      salt    = s;
      latMode = lat;
      staleEn = stale;
      @(negedge clk);
      start       = 1'b1;
      output_addr = base;
      @(negedge clk);
      start       = 1'b0;
      output_addr = 16'($urandom);
      cycles      = 0;
      while (mRunning && (cycles < 3000)) begin
         if ((abortAfter > 0) && (mWrites >= abortAfter)) break;
         gate  = contend ? ((cycles % 12) == 11) : 1'b1;
         start = spam && ($urandom_range(0, 3) == 0);
         @(negedge clk);
         cycles++;
      end
      start = 1'b0;
      gate  = 1'b1;

      if (abortAfter > 0) begin
         @(negedge clk);
         reset_n = 1'b0;
         #1;
         checkResetOutputs();
         mRunning = 1'b0;
         mDone    = 1'b0;
         for (int i = 0; i < NUM_CORES; i++) mBusy[i] = 1'b0;
         expQ.delete();
         repeat (2) @(negedge clk);
         reset_n = 1'b1;
      end else begin
         if (mRunning) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL runTimeout: got %0d writes after %0d cycles, expected %0d", mWrites, cycles, NUM_NONCES);
         end
         @(negedge clk);
         checkOutput("runDone", {31'b0, done}, 32'd1);
         checkOutput("writeCount", 32'(mWeCount), 32'(NUM_NONCES));
         checkOutput("pendingWrites", 32'(expQ.size()), 32'd0);
         repeat (10) @(negedge clk);
         checkOutput("writeCountIdle", 32'(mWeCount), 32'(NUM_NONCES));
         checkOutput("doneHeld", {31'b0, done}, 32'd1);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      start       = 1'b0;
      output_addr = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         mBusy[i] = 1'b0;
         mTag[i]  = 0;
      end
      repeat (3) @(negedge clk);
      checkResetOutputs();
      reset_n = 1'b1;

      $display("[TB] basic run");
      applyStimulus(16'h0100, 8'h00, 10, 1'b0, 1'b0, 1'b0, 0);
      $display("[TB] random latency, stale valids, start while running");
      applyStimulus(16'($urandom), 8'h11, 12, 1'b1, 1'b0, 1'b1, 0);
      $display("[TB] address wrap");
      applyStimulus(16'hFFFE, 8'h22, 6, 1'b0, 1'b0, 1'b0, 0);
      $display("[TB] contention");
      applyStimulus(16'($urandom), 8'h33, 0, 1'b0, 1'b1, 1'b0, 0);
      $display("[TB] reset mid-run");
      applyStimulus(16'h0200, 8'h44, 8, 1'b0, 1'b0, 1'b0, 5);
      $display("[TB] replay after reset");
      applyStimulus(16'h0200, 8'h55, 8, 1'b1, 1'b0, 1'b1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
